// File: rtl/pcie_vc_sched.sv
// Flow-control sequencer for the PCIe VC datapath: thresholds, pop strobes, VC0/VC1 WRR arbitration.
// Define PCIE_VC_STRICT_PRIO_EN to replace WRR with strict VC0-over-VC1 priority.
module pcie_vc_sched #(
   parameter int unsigned LENGTH  = 4,
   parameter int unsigned WEIGHT0 = 3,
   parameter int unsigned WEIGHT1 = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [LENGTH-1:0] umbral_mf_in,
   input  logic [LENGTH-1:0] umbral_vc_in,
   input  logic [LENGTH-1:0] umbral_d_in,
   input  logic              main_empty,
   input  logic              vc0_empty,
   input  logic              vc1_empty,
   input  logic              vc0_pause,
   input  logic              vc1_pause,
   input  logic              d0_pause,
   input  logic              d1_pause,
   input  logic              fifo_error,
   output logic              pop_main,
   output logic              pop_vc0,
   output logic              pop_vc1,
   output logic [LENGTH-1:0] umbral_mf,
   output logic [LENGTH-1:0] umbral_vc,
   output logic [LENGTH-1:0] umbral_d,
   output logic [2:0]        state,
   output logic              cur_vc,
   output logic              idle,
   output logic              error
);

   localparam logic [2:0] ST_RESET  = 3'd0;
   localparam logic [2:0] ST_INIT   = 3'd1;
   localparam logic [2:0] ST_IDLE   = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;
   localparam logic [2:0] ST_ERROR  = 3'd4;

   localparam logic [3:0] W0 = 4'(WEIGHT0);
   localparam logic [3:0] W1 = 4'(WEIGHT1);

   logic [2:0]        state_q, state_d;
   logic [LENGTH-1:0] umbral_mf_q, umbral_mf_d;
   logic [LENGTH-1:0] umbral_vc_q, umbral_vc_d;
   logic [LENGTH-1:0] umbral_d_q, umbral_d_d;
   logic              cur_vc_q, cur_vc_d;
   logic [3:0]        credit_q, credit_d;
   logic              active, go, any_data;

   assign active   = (state_q == ST_ACTIVE);
   assign go       = active & ~(d0_pause | d1_pause);
   assign any_data = ~(main_empty & vc0_empty & vc1_empty);

   always_comb begin
      state_d     = state_q;
      umbral_mf_d = umbral_mf_q;
      umbral_vc_d = umbral_vc_q;
      umbral_d_d  = umbral_d_q;
      if (state_q != ST_RESET && fifo_error) begin
         state_d = ST_ERROR;
      end else begin
         case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
               if (init) begin
                  umbral_mf_d = umbral_mf_in;
                  umbral_vc_d = umbral_vc_in;
                  umbral_d_d  = umbral_d_in;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (init)          state_d = ST_INIT;
               else if (any_data) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (init)           state_d = ST_INIT;
               else if (!any_data) state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
         endcase
      end
   end

   assign pop_main = active & ~main_empty & ~(vc0_pause | vc1_pause);

`ifdef PCIE_VC_STRICT_PRIO_EN
   assign pop_vc0 = go & ~vc0_empty;
   assign pop_vc1 = go & ~vc1_empty & vc0_empty;

   always_comb begin
      cur_vc_d = 1'b0;
      credit_d = credit_q;
   end
`else
   logic       sel;
   logic       s;
   logic [3:0] w_s;

   // sel=1 picks VC1; an empty turn holder yields to the other VC (work-conserving)
   assign sel     = cur_vc_q ? ~vc1_empty : vc0_empty;
   assign pop_vc0 = go & ~sel & ~vc0_empty;
   assign pop_vc1 = go & sel & ~vc1_empty;
   assign s       = pop_vc1;
   assign w_s     = s ? W1 : W0;

   always_comb begin
      cur_vc_d = cur_vc_q;
      credit_d = credit_q;
      if (pop_vc0 | pop_vc1) begin
         if (s == cur_vc_q) begin
            if (credit_q == 4'd1) begin
               cur_vc_d = ~s;
               credit_d = s ? W0 : W1;
            end else begin
               credit_d = credit_q - 4'd1;
            end
         end else if (w_s == 4'd1) begin
            // borrowed turn that uses the whole weight hands the turn straight back
            cur_vc_d = ~s;
            credit_d = s ? W0 : W1;
         end else begin
            cur_vc_d = s;
            credit_d = w_s - 4'd1;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RESET;
         umbral_mf_q <= LENGTH'(1);
         umbral_vc_q <= LENGTH'(1);
         umbral_d_q  <= LENGTH'(1);
         cur_vc_q    <= 1'b0;
         credit_q    <= W0;
      end else begin
         state_q     <= state_d;
         umbral_mf_q <= umbral_mf_d;
         umbral_vc_q <= umbral_vc_d;
         umbral_d_q  <= umbral_d_d;
         cur_vc_q    <= cur_vc_d;
         credit_q    <= credit_d;
      end
   end

   assign umbral_mf = umbral_mf_q;
   assign umbral_vc = umbral_vc_q;
   assign umbral_d  = umbral_d_q;
   assign state     = state_q;
   assign cur_vc    = cur_vc_q;
   assign idle      = (state_q == ST_IDLE);
   assign error     = (state_q == ST_ERROR);

endmodule
